// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-divide step
// per cycle, a sign-fix cycle, and MTHI/MTLO writes from IDLE.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             md_i_clk,
    input  logic             md_i_rst,
    input  logic             md_i_start,
    input  logic [2:0]       md_i_op,
    input  logic [WIDTH-1:0] md_i_a,
    input  logic [WIDTH-1:0] md_i_b,
    input  logic             md_i_read,
    input  logic             md_i_flush,
    output logic [WIDTH-1:0] md_o_hi,
    output logic [WIDTH-1:0] md_o_lo,
    output logic             md_o_busy,
    output logic             md_o_stall,
    output logic             md_o_done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    w_acc_nxt;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] w_mag_b_nxt;
    logic             r_is_div;
    logic             w_is_div_nxt;
    logic             r_neg_q;
    logic             w_neg_q_nxt;
    logic             r_neg_r;
    logic             w_neg_r_nxt;
    logic             r_div0;
    logic             w_div0_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_busy;

    // Operand decode and magnitude capture for an accepted start
    logic             w_op_md;
    logic             w_op_signed;
    logic             w_op_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_op_md     = (md_i_op == OP_MULT) || (md_i_op == OP_MULTU) ||
                         (md_i_op == OP_DIV)  || (md_i_op == OP_DIVU);
    assign w_op_signed = (md_i_op == OP_MULT) || (md_i_op == OP_DIV);
    assign w_op_div    = (md_i_op == OP_DIV)  || (md_i_op == OP_DIVU);
    assign w_a_neg     = w_op_signed & md_i_a[WIDTH-1];
    assign w_b_neg     = w_op_signed & md_i_b[WIDTH-1];
    assign w_mag_a     = w_a_neg ? (WIDTH'(0) - md_i_a) : md_i_a;
    assign w_mag_b     = w_b_neg ? (WIDTH'(0) - md_i_b) : md_i_b;

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]   w_mul_sum;
    logic [AW-1:0]    w_mul_acc;

    assign w_mul_sum = {1'b0, r_acc[AW-1:WIDTH]} +
                       {1'b0, (r_acc[0] ? r_mag_b : WIDTH'(0))};
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide step: acc = {remainder, dividend bits / quotient bits}
    logic [WIDTH:0]   w_div_part;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [AW-1:0]    w_div_acc;

    assign w_div_part = r_acc[AW-1:WIDTH-1];
    assign w_div_ge   = (w_div_part >= {1'b0, r_mag_b});
    assign w_div_diff = w_div_part[WIDTH-1:0] - r_mag_b;
    assign w_div_acc  = {(w_div_ge ? w_div_diff : w_div_part[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    // Sign correction applied in FIX
    logic [AW-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_prod = r_neg_q ? (AW'(0) - r_acc) : r_acc;
    assign w_quo  = r_div0  ? {WIDTH{1'b1}}
                  : (r_neg_q ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_r ? (WIDTH'(0) - r_acc[AW-1:WIDTH]) : r_acc[AW-1:WIDTH];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mag_b_nxt  = r_mag_b;
        w_is_div_nxt = r_is_div;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_div0_nxt   = r_div0;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (md_i_start && !md_i_flush) begin
                    if (w_op_md) begin
                        w_state_nxt  = S_RUN;
                        w_cnt_nxt    = CW'(WIDTH - 1);
                        w_acc_nxt    = {WIDTH'(0), w_mag_a};
                        w_mag_b_nxt  = w_mag_b;
                        w_is_div_nxt = w_op_div;
                        w_neg_q_nxt  = w_a_neg ^ w_b_neg;
                        w_neg_r_nxt  = w_a_neg;
                        w_div0_nxt   = (md_i_b == WIDTH'(0));
                    end else if (md_i_op == OP_MTHI) begin
                        w_hi_nxt = md_i_a;
                    end else if (md_i_op == OP_MTLO) begin
                        w_lo_nxt = md_i_a;
                    end
                end
            end
            S_RUN: begin
                if (md_i_flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;
                    if (r_cnt == CW'(0)) begin
                        w_state_nxt = S_FIX;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
                if (!md_i_flush) begin
                    w_done_nxt = 1'b1;
                    if (r_is_div) begin
                        w_hi_nxt = w_rem;
                        w_lo_nxt = w_quo;
                    end else begin
                        w_hi_nxt = w_prod[AW-1:WIDTH];
                        w_lo_nxt = w_prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge md_i_clk) begin
        if (md_i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= CW'(0);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge md_i_clk) begin
        if (md_i_rst) begin
            r_acc    <= AW'(0);
            r_mag_b  <= WIDTH'(0);
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= WIDTH'(0);
            r_lo     <= WIDTH'(0);
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_mag_b  <= w_mag_b_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_div0   <= w_div0_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    assign md_o_hi    = r_hi;
    assign md_o_lo    = r_lo;
    assign md_o_busy  = r_busy;
    assign md_o_done  = r_done;
    assign md_o_stall = r_busy & (md_i_start | md_i_read);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, scoreboard on done, and
// hand-written flush/reset/stall sequences.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned LAT = W + 1;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rd;
    logic         flush;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         stall;
    logic         done;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .md_i_clk   (clk),
        .md_i_rst   (rst),
        .md_i_start (start),
        .md_i_op    (op),
        .md_i_a     (a),
        .md_i_b     (b),
        .md_i_read  (rd),
        .md_i_flush (flush),
        .md_o_hi    (hi),
        .md_o_lo    (lo),
        .md_o_busy  (busy),
        .md_o_stall (stall),
        .md_o_done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding result
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_hi", 64'(hi), 64'(e.hi));
                check("sb_lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        q.push_back(e);
    endtask

    // Present a one-cycle start from the current (post-edge) time
    task automatic drive_start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = OP_NOP;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    vec_t vecs[11];
    int   cyc;
    int   nstall;

    initial begin
        vecs[0]  = '{"mult_7_m3",      OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{"multu_max",      OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"div_m7_2",       OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",       OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[4]  = '{"div_min_m1",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_256_7",     OP_DIVU,  32'h00000100, 32'h00000007, 32'h00000004, 32'h00000024};
        vecs[6]  = '{"multu_carry",    OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{"div_100_m7",     OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
        vecs[8]  = '{"mult_m1_m1",     OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[9]  = '{"div_m5_by0",     OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{"mult_min_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rst = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0; rd = 1'b0; flush = 1'b0;
        repeat (3) tick();
        rd = 1'b1;
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        rd = 1'b0;
        rst = 1'b0;
        tick();

        drive_start(OP_MTHI, 32'hA5A5A5A5, '0);
        check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        check("mthi_busy", 64'(busy), 64'(0));
        drive_start(OP_MTLO, 32'h5A5A5A5A, '0);
        check("mtlo_lo", 64'(lo), 64'h5A5A5A5A);
        check("mtlo_hi_kept", 64'(hi), 64'hA5A5A5A5);
        check("mt_no_done", 64'(done), 64'(0));

        foreach (vecs[i]) begin
            push_exp(vecs[i].hi, vecs[i].lo);
            drive_start(vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_busy"}, 64'(busy), 64'(1));
            wait_done(cyc);
            check({vecs[i].name, "_latency"}, 64'(cyc), 64'(LAT));
            tick();
            check({vecs[i].name, "_pulse"}, 64'(done), 64'(0));
        end

        // Start in the done cycle is accepted immediately
        push_exp(32'd1, 32'd333);
        drive_start(OP_DIVU, 32'd1000, 32'd3);
        wait_done(cyc);
        check("b2b_first_latency", 64'(cyc), 64'(LAT));
        push_exp(32'd0, 32'd30);
        drive_start(OP_MULTU, 32'd5, 32'd6);
        check("b2b_busy", 64'(busy), 64'(1));
        wait_done(cyc);
        check("b2b_second_latency", 64'(cyc), 64'(LAT));
        tick();

        // Stall counts busy cycles while the pipeline reads HI/LO
        drive_start(OP_MTHI, 32'hA5A5A5A5, '0);
        check("mthi2_hi", 64'(hi), 64'hA5A5A5A5);
        rd = 1'b1;
        push_exp(32'd0, 32'd12);
        drive_start(OP_MULT, 32'd3, 32'd4);
        nstall = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (stall === 1'b1) nstall++;
            tick();
            cyc++;
        end
        check("read_stall_cycles", 64'(nstall), 64'(LAT));
        check("read_stall_low_at_done", 64'(stall), 64'(0));
        rd = 1'b0;
        tick();

        // MTHI held while busy is ignored, then lands once idle
        push_exp(32'd1, 32'd333);
        drive_start(OP_DIVU, 32'd1000, 32'd3);
        start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
        repeat (9) tick();
        check("busy_mthi_stall", 64'(stall), 64'(1));
        check("busy_mthi_hi", 64'(hi), 64'(0));
        wait_done(cyc);
        check("busy_mthi_latency", 64'(cyc), 64'(LAT - 9));
        tick();
        start = 1'b0; op = OP_NOP;
        check("mthi_after_done", 64'(hi), 64'hDEADBEEF);
        tick();

        // Flush during RUN cycle 10
        drive_start(OP_MTHI, 32'h11111111, '0);
        drive_start(OP_MTLO, 32'h22222222, '0);
        drive_start(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_hi", 64'(hi), 64'h11111111);
        check("flush_lo", 64'(lo), 64'h22222222);
        check("flush_done", 64'(done), 64'(0));
        push_exp(32'd6, 32'd142);
        drive_start(OP_DIVU, 32'd1000, 32'd7);
        wait_done(cyc);
        check("after_flush_latency", 64'(cyc), 64'(LAT));
        tick();

        // Reset during RUN cycle 5
        drive_start(OP_MULT, 32'd7, 32'd9);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        repeat (40) tick();

        // Flush beats start in IDLE
        flush = 1'b1;
        drive_start(OP_MTHI, 32'h00000055, '0);
        check("idle_flush_mthi", 64'(hi), 64'(0));
        drive_start(OP_MULT, 32'd2, 32'd2);
        check("idle_flush_mult", 64'(busy), 64'(0));
        flush = 1'b0;

        // Reset beats start
        rst = 1'b1;
        drive_start(OP_MULT, 32'd2, 32'd2);
        rst = 1'b0;
        check("rst_over_start", 64'(busy), 64'(0));
        repeat (40) tick();

        check("sb_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand and HI/LO register width.
REQ-002 md_i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 md_i_rst  input  1  synchronous, active-high reset.
REQ-004 md_i_start  input  1  request valid; the op is sampled when high.
REQ-005 md_i_op  input  3  op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP.
REQ-006 md_i_a, md_i_b  input  WIDTH each  operands; md_i_a is the dividend or the MTHI/MTLO source, md_i_b is the divisor.
REQ-007 md_i_read  input  1  the pipeline is reading HI or LO (MFHI/MFLO) this cycle.
REQ-008 md_i_flush  input  1  abort any in-flight operation.
REQ-009 md_o_hi, md_o_lo  output  WIDTH each  architectural HI/LO registers.
REQ-010 md_o_busy  output  1  high whenever state is not IDLE.
REQ-011 md_o_stall  output  1  combinational; equals md_o_busy AND (md_i_start OR md_i_read).
REQ-012 md_o_done  output  1  one-cycle pulse when HI/LO receive a MULT/DIV result.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and FIX, plus an iteration counter of clog2(WIDTH) bits.
REQ-014 IDLE transitions:
- md_i_start=1 with op 1-4 and md_i_flush=0: latch operand magnitudes (absolute values for MULT/DIV, raw values for MULTU/DIVU), latch the sign flags, load counter=WIDTH-1, go to RUN.
- op 5 (MTHI) or op 6 (MTLO): write md_i_a into HI or LO at that edge; stay in IDLE; md_o_done stays 0.
- op 0 or 7: no effect.
REQ-015 RUN SHALL perform one iteration per cycle:
- multiply: shift-add, 2*WIDTH-bit product accumulator.
- divide: restoring, one quotient bit per cycle.
- Counter decrements each cycle; at counter=0 the next state is FIX, so RUN lasts exactly WIDTH cycles.
REQ-016 FIX SHALL occupy one cycle and:
- apply sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
- write HI (upper product half or remainder) and LO (lower product half or quotient) at its edge.
- set md_o_done=1 for the following cycle.
- return to IDLE.
REQ-017 Latency: if a start is accepted at edge E, HI/LO SHALL update at edge E+WIDTH+1, md_o_done SHALL be high in the cycle after that edge, and md_o_busy SHALL be high for WIDTH+1 cycles.
REQ-018 Divide by zero (md_i_b=0) SHALL give LO = all ones and HI = md_i_a, for both DIV and DIVU.
REQ-019 Signed DIV of the most-negative value by -1 SHALL give LO = the most-negative value and HI = 0.
REQ-020 While busy, md_i_start SHALL be ignored for every op, including MTHI/MTLO, and md_o_stall SHALL be high; the requester holds its request until md_o_stall falls.
REQ-021 A start presented in the cycle md_o_done is high SHALL be accepted normally, because the state is already IDLE.
REQ-022 md_i_flush=1 in RUN or FIX SHALL force IDLE at the next edge, leave HI/LO unchanged, and suppress md_o_done; in IDLE, flush SHALL take priority over a simultaneous start.
REQ-023 md_o_hi and md_o_lo SHALL change only at a FIX edge, an MTHI/MTLO edge, or reset.

Reset
REQ-024 While md_i_rst is high, at the clock edge:
- state becomes IDLE and the counter becomes 0;
- HI=0, LO=0;
- md_o_busy=0 and md_o_done=0;
- the internal accumulators are cleared.
REQ-025 Reset mid-operation SHALL discard the operation with no done pulse, and reset SHALL take priority over start and flush.

Verification
REQ-026 MULT a=7, b=0xFFFFFFFD (-3) -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, with a one-cycle done pulse.
REQ-027 MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-029 MTHI 0xA5A5A5A5, then MULT 3*4 with md_i_read=1 held -> stall high for 33 cycles; final HI=0, LO=12.
REQ-030 DIVU started, flush at RUN cycle 10 -> IDLE next cycle, HI/LO keep their prior values, no done; a new start the next cycle completes correctly.
REQ-031 md_i_rst asserted at RUN cycle 5 -> next cycle busy=0 and HI=LO=0, with no done pulse.
